// File: rtl/vid_timing_pkg.sv
// Shared constants for the video timing generator: pattern selects, 1080p60 raster,
// colour-bar table and the CRC-32 step used by the optional frame checksum.
package vid_timing_pkg;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_GRAY  = 2'd3;

    localparam int H_WIDTH_1080P  = 1920;
    localparam int H_START_1080P  = 2008;
    localparam int H_SYNC_1080P   = 44;
    localparam int H_TOTAL_1080P  = 2200;
    localparam int V_HEIGHT_1080P = 1080;
    localparam int V_START_1080P  = 1084;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_TOTAL_1080P  = 1125;
    localparam int KH_DEF         = 30;
    localparam int KV_DEF         = 30;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };
    localparam logic [23:0] GRAY_RGB = 24'h808080;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vtg_state_t;

    // One pixel, MSB first, non-reflected.
    function automatic logic [31:0] crc32_px(input logic [31:0] crc, input logic [23:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vid_pattern_gen.sv
// Test-pattern pixel generator: bars, ramp, checkerboard, gray. Bar and checker
// positions come from down-counters aligned to the raster counters, output is registered.
module vid_pattern_gen
    import vid_timing_pkg::*;
#(
    parameter int H_WIDTH  = H_WIDTH_1080P,
    parameter int V_HEIGHT = V_HEIGHT_1080P,
    parameter int KH       = KH_DEF,
    parameter int KV       = KV_DEF
) (
    input  logic        vin_clk_i,
    input  logic        rst_n,
    input  logic        run,
    input  logic [11:0] h,
    input  logic [10:0] v,
    input  logic        h_wrap,
    input  logic        frame_wrap,
    input  logic        active,
    input  logic [1:0]  pattern,
    output logic [23:0] rgb_o
);
    localparam int          BAR_W    = (H_WIDTH / 8 > 0) ? H_WIDTH / 8 : 1;
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
    localparam logic [11:0] KH_LAST  = 12'(KH - 1);
    localparam logic [10:0] KV_LAST  = 11'(KV - 1);
    localparam logic [10:0] V_ACT    = 11'(V_HEIGHT);

    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic [11:0] kh_cnt;
    logic        kh_par;
    logic [10:0] kv_cnt;
    logic        kv_par;
    logic [11:0] h_div8;
    logic [7:0]  ramp;
    logic [23:0] rgb_nxt;

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bar_cnt <= BAR_LAST;
            bar_idx <= '0;
            kh_cnt  <= KH_LAST;
            kh_par  <= 1'b0;
        end else if (!run || h_wrap) begin
            bar_cnt <= BAR_LAST;
            bar_idx <= '0;
            kh_cnt  <= KH_LAST;
            kh_par  <= 1'b0;
        end else begin
            // Last bar absorbs any remainder pixels of a width not divisible by 8.
            if (bar_cnt == '0) begin
                bar_cnt <= BAR_LAST;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt - 12'd1;
            end
            if (kh_cnt == '0) begin
                kh_cnt <= KH_LAST;
                kh_par <= ~kh_par;
            end else begin
                kh_cnt <= kh_cnt - 12'd1;
            end
        end
    end

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            kv_cnt <= KV_LAST;
            kv_par <= 1'b0;
        end else if (!run || frame_wrap) begin
            kv_cnt <= KV_LAST;
            kv_par <= 1'b0;
        end else if (h_wrap && (v < V_ACT)) begin
            if (kv_cnt == '0) begin
                kv_cnt <= KV_LAST;
                kv_par <= ~kv_par;
            end else begin
                kv_cnt <= kv_cnt - 11'd1;
            end
        end
    end

    assign h_div8 = h >> 3;
    assign ramp   = (h_div8 > 12'd255) ? 8'hFF : h_div8[7:0];

    always_comb begin
        rgb_nxt = '0;
        case (pattern)
            PAT_BARS:  rgb_nxt = BAR_RGB[bar_idx];
            PAT_RAMP:  rgb_nxt = {ramp, ramp, ramp};
            PAT_CHECK: rgb_nxt = (kh_par ^ kv_par) ? 24'h000000 : 24'hFFFFFF;
            default:   rgb_nxt = GRAY_RGB;
        endcase
    end

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n)             rgb_o <= '0;
        else if (run && active) rgb_o <= rgb_nxt;
        else                    rgb_o <= '0;
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing (hs/vs/de) and test-pattern source on vin_clk_i.
// Define VID_TIMING_GEN_CRC_EN to add a per-frame CRC-32 of the active pixels.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_WIDTH  = H_WIDTH_1080P,
    parameter int H_START  = H_START_1080P,
    parameter int H_SYNC   = H_SYNC_1080P,
    parameter int H_TOTAL  = H_TOTAL_1080P,
    parameter int V_HEIGHT = V_HEIGHT_1080P,
    parameter int V_START  = V_START_1080P,
    parameter int V_SYNC   = V_SYNC_1080P,
    parameter int V_TOTAL  = V_TOTAL_1080P,
    parameter int KH       = KH_DEF,
    parameter int KV       = KV_DEF
) (
    input  logic        vin_clk_i,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [1:0]  pattern_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic        sof_o,
    output logic [11:0] x_o,
    output logic [10:0] y_o
`ifdef VID_TIMING_GEN_CRC_EN
    ,
    output logic [31:0] crc_o,
    output logic        crc_valid_o
`endif
);
    // state   | meaning
    // ST_IDLE | counters held at 0, outputs 0, waiting for en_i
    // ST_RUN  | raster running; leaves only at the frame end cycle with en_i low

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_WIDTH);
    localparam logic [10:0] V_ACT  = 11'(V_HEIGHT);
    localparam logic [11:0] HS_BEG = 12'(H_START);
    localparam logic [11:0] HS_END = 12'(H_START + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_START);
    localparam logic [10:0] VS_END = 11'(V_START + V_SYNC);

    vtg_state_t  state, state_nxt;
    logic [11:0] h;
    logic [10:0] v;
    logic        run, h_wrap, frame_end, frame_start, active;
    logic [1:0]  pat_q, pat_cur;

    assign run         = (state == ST_RUN);
    assign h_wrap      = run && (h == H_LAST);
    assign frame_end   = h_wrap && (v == V_LAST);
    assign frame_start = run && (h == '0) && (v == '0);
    assign active      = (h < H_ACT) && (v < V_ACT);
    assign pat_cur     = frame_start ? pattern_i : pat_q;

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en_i) state_nxt = ST_RUN;
            ST_RUN:  if (frame_end && !en_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            h     <= '0;
            v     <= '0;
            pat_q <= PAT_BARS;
        end else if (!run) begin
            h <= '0;
            v <= '0;
        end else begin
            if (frame_start) pat_q <= pattern_i;
            if (h_wrap) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 11'd1;
            end else begin
                h <= h + 12'd1;
            end
        end
    end

    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            de_o  <= 1'b0;
            hs_o  <= 1'b0;
            vs_o  <= 1'b0;
            sof_o <= 1'b0;
            x_o   <= '0;
            y_o   <= '0;
        end else if (run) begin
            de_o  <= active;
            hs_o  <= (h >= HS_BEG) && (h < HS_END);
            vs_o  <= (v >= VS_BEG) && (v < VS_END);
            sof_o <= (h == '0) && (v == '0);
            x_o   <= h;
            y_o   <= v;
        end else begin
            de_o  <= 1'b0;
            hs_o  <= 1'b0;
            vs_o  <= 1'b0;
            sof_o <= 1'b0;
            x_o   <= '0;
            y_o   <= '0;
        end
    end

    vid_pattern_gen #(
        .H_WIDTH  (H_WIDTH),
        .V_HEIGHT (V_HEIGHT),
        .KH       (KH),
        .KV       (KV)
    ) u_pattern (
        .vin_clk_i  (vin_clk_i),
        .rst_n      (rst_n),
        .run        (run),
        .h          (h),
        .v          (v),
        .h_wrap     (h_wrap),
        .frame_wrap (frame_end),
        .active     (active),
        .pattern    (pat_cur),
        .rgb_o      (data_o)
    );

`ifdef VID_TIMING_GEN_CRC_EN
    logic [31:0] crc_acc;
    logic        last_px;

    assign last_px = de_o && (x_o == H_ACT - 12'd1) && (y_o == V_ACT - 11'd1);

    // Runs on the registered pixel stream so the checksum matches what leaves the block.
    always_ff @(posedge vin_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc     <= CRC_INIT;
            crc_o       <= '0;
            crc_valid_o <= 1'b0;
        end else begin
            crc_valid_o <= 1'b0;
            if (de_o) begin
                if (last_px) begin
                    crc_o       <= crc32_px(crc_acc, data_o);
                    crc_valid_o <= 1'b1;
                    crc_acc     <= CRC_INIT;
                end else begin
                    crc_acc <= crc32_px(crc_acc, data_o);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen on a small raster with a frame-position model.
module tb_vid_timing_gen;
    localparam int HW = 16, HST = 18, HSY = 2, HT = 22;
    localparam int VH = 8, VST = 9, VSY = 1, VT = 11;
    localparam int KH = 4, KV = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [1:0]  pattern_i;
    logic        hs_o, vs_o, de_o, sof_o;
    logic [23:0] data_o;
    logic [11:0] x_o;
    logic [10:0] y_o;
`ifdef VID_TIMING_GEN_CRC_EN
    logic [31:0] crc_o;
    logic        crc_valid_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vid_timing_gen #(
        .H_WIDTH(HW), .H_START(HST), .H_SYNC(HSY), .H_TOTAL(HT),
        .V_HEIGHT(VH), .V_START(VST), .V_SYNC(VSY), .V_TOTAL(VT),
        .KH(KH), .KV(KV)
    ) dut (
        .vin_clk_i (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .pattern_i (pattern_i),
        .hs_o      (hs_o),
        .vs_o      (vs_o),
        .de_o      (de_o),
        .data_o    (data_o),
        .sof_o     (sof_o),
        .x_o       (x_o),
        .y_o       (y_o)
`ifdef VID_TIMING_GEN_CRC_EN
        ,
        .crc_o       (crc_o),
        .crc_valid_o (crc_valid_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame as one number, outputs from plain arithmetic.
    function automatic logic [23:0] exp_pix(input int h, input int v, input logic [1:0] pat);
        logic [23:0] bars [8];
        int b;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        if (h >= HW || v >= VH) return 24'h0;
        case (pat)
            2'd0: begin
                b = h / (HW / 8);
                if (b > 7) b = 7;
                return bars[b];
            end
            2'd1: begin
                b = (h / 8 > 255) ? 255 : h / 8;
                return {3{8'(b)}};
            end
            2'd2: return ((((h / KH) + (v / KV)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h808080;
        endcase
    endfunction

    bit          m_run;
    int          m_p;
    logic [1:0]  m_pat;
    logic        e_de, e_hs, e_vs, e_sof;
    logic [23:0] e_data;
    logic [11:0] e_x;
    logic [10:0] e_y;

    always @(posedge clk or negedge rst_n) begin : model
        int h, v;
        logic [1:0] pat;
        if (!rst_n) begin
            m_run <= 0; m_p <= 0; m_pat <= 0;
            e_de <= 0; e_hs <= 0; e_vs <= 0; e_sof <= 0; e_data <= 0; e_x <= 0; e_y <= 0;
        end else if (m_run) begin
            h   = m_p % HT;
            v   = m_p / HT;
            pat = (m_p == 0) ? pattern_i : m_pat;
            if (m_p == 0) m_pat <= pattern_i;
            e_de   <= (h < HW) && (v < VH);
            e_hs   <= (h >= HST) && (h < HST + HSY);
            e_vs   <= (v >= VST) && (v < VST + VSY);
            e_sof  <= (m_p == 0);
            e_x    <= 12'(h);
            e_y    <= 11'(v);
            e_data <= exp_pix(h, v, pat);
            if (m_p == HT * VT - 1) begin
                m_p   <= 0;
                m_run <= en_i;
            end else begin
                m_p <= m_p + 1;
            end
        end else begin
            e_de <= 0; e_hs <= 0; e_vs <= 0; e_sof <= 0; e_data <= 0; e_x <= 0; e_y <= 0;
            if (en_i) begin
                m_run <= 1;
                m_p   <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("m_de", de_o, e_de);
        check("m_hs", hs_o, e_hs);
        check("m_vs", vs_o, e_vs);
        check("m_sof", sof_o, e_sof);
        check("m_x", x_o, e_x);
        check("m_y", y_o, e_y);
        check("m_data", data_o, e_data);
    end

    task automatic wait_xy(input int x, input int y, input string name);
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (x_o == 12'(x) && y_o == 11'(y)) found = 1;
        end
        check(name, found, 1);
    endtask

    task automatic count_to_sof(input string name, input int exp);
        int cnt = 0;
        bit found = 0;
        while (!found && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (sof_o) found = 1;
        end
        if (exp > 0) check(name, cnt, exp);
        else         check(name, found, 1);
    endtask

    initial begin
        logic [23:0] bar_lit [8];
        bar_lit = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        rst_n = 0; en_i = 0; pattern_i = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_de", de_o, 0);
        check("rst_sof", sof_o, 0);
        check("rst_data", data_o, 0);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("idle_x", x_o, 0);

        en_i = 1;
        count_to_sof("start_lat", 2);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("bar_px%0d", i), data_o, bar_lit[i / 2]);
        end
        wait_xy(18, 0, "reach_18_0");
        check("hs_18", hs_o, 1);
        wait_xy(19, 0, "reach_19_0");
        check("hs_19", hs_o, 1);
        wait_xy(20, 0, "reach_20_0");
        check("hs_20", hs_o, 0);
        wait_xy(5, 3, "reach_5_3");
        pattern_i = 2'd3;
        wait_xy(2, 4, "reach_2_4");
        check("bar_keep", data_o, 24'hFFFF00);
        wait_xy(21, 8, "reach_21_8");
        check("vs_pre", vs_o, 0);
        @(negedge clk);
        check("vs_9_0", vs_o, 1);
        wait_xy(21, 9, "reach_21_9");
        check("vs_9_21", vs_o, 1);
        @(negedge clk);
        check("vs_10", vs_o, 0);

        count_to_sof("sof_f2", 0);
        check("gray_00", data_o, 24'h808080);
        pattern_i = 2'd2;
        count_to_sof("sof_period", HT * VT);
        check("chk_0_0", data_o, 24'hFFFFFF);
        wait_xy(3, 0, "reach_3_0");
        check("chk_3_0", data_o, 24'hFFFFFF);
        wait_xy(4, 0, "reach_4_0");
        check("chk_4_0", data_o, 24'h000000);
        wait_xy(7, 0, "reach_7_0");
        check("chk_7_0", data_o, 24'h000000);
        wait_xy(8, 0, "reach_8_0");
        check("chk_8_0", data_o, 24'hFFFFFF);
        wait_xy(0, 1, "reach_0_1");
        check("chk_0_1", data_o, 24'hFFFFFF);
        wait_xy(0, 2, "reach_0_2");
        check("chk_0_2", data_o, 24'h000000);
        wait_xy(4, 2, "reach_4_2");
        check("chk_4_2", data_o, 24'hFFFFFF);
        pattern_i = 2'd1;

        count_to_sof("sof_f4", 0);
        wait_xy(7, 0, "reach_r7");
        check("ramp_7", data_o, 24'h000000);
        wait_xy(8, 0, "reach_r8");
        check("ramp_8", data_o, 24'h010101);
        wait_xy(0, 3, "reach_0_3");
        en_i = 0;
        wait_xy(21, 10, "reach_end");
        @(negedge clk);
        check("stop_de", de_o, 0);
        check("stop_sof", sof_o, 0);
        check("stop_y", y_o, 0);
        repeat (20) @(negedge clk);
        check("stop_x", x_o, 0);
        en_i = 1;
        count_to_sof("restart_lat", 2);

        wait_xy(5, 2, "reach_5_2");
        #1 rst_n = 0;
        #1;
        check("arst_de", de_o, 0);
        check("arst_x", x_o, 0);
        check("arst_y", y_o, 0);
        check("arst_data", data_o, 0);
        @(negedge clk);
        rst_n = 1;
        count_to_sof("post_rst_lat", 2);
        check("post_rst_x", x_o, 0);
        repeat (300) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
